// File: rtl/iob_fifo_pkg.sv
// Shared constants and types for the synchronous FIFO read-side front-ends.
package iob_fifo_pkg;

    localparam int unsigned FIFO_RD_LAT = 1;
    localparam int unsigned SKID_DEPTH  = 2;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/iob_skid_buf2.sv
// Two-entry valid/ready skid buffer; head entry drives the output data.
module iob_skid_buf2
    import iob_fifo_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] data,
    output occ_t         occ
);

    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    occ_t         r_occ;

    // Caller guarantees push never targets a full buffer and pop only when valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (r_occ == 2'd0) r_head <= push_data;
                    else               r_tail <= push_data;
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_head <= push_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid = (r_occ != 2'd0);
    assign data  = r_head;
    assign occ   = r_occ;

endmodule

// File: rtl/iob_fifo_burst_reader.sv
// Drains a length-bounded burst from a synchronous FIFO onto a valid/ready stream.
module iob_fifo_burst_reader
    import iob_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    input  logic              fifo_empty,
    output logic              fifo_read_en,
    input  logic [DATA_W-1:0] fifo_r_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    typedef logic [FIFO_RD_LAT-1:0] rd_pipe_t;

    logic             r_busy;
    logic [LEN_W-1:0] r_rd_left;
    logic [LEN_W-1:0] r_tx_left;
    rd_pipe_t         r_rd_pipe;

    logic       w_pop;
    logic       w_push;
    logic       w_accept;
    logic       w_read_en;
    occ_t       w_occ;
    logic [2:0] w_level;

    assign w_pop    = m_valid && m_ready;
    assign w_push   = r_rd_pipe[FIFO_RD_LAT-1];
    assign w_accept = start && !r_busy && (len != '0);

    // Words already buffered plus words still in flight must leave room for one more.
    assign w_level   = 3'(w_occ) + 3'($countones(r_rd_pipe));
    assign w_read_en = r_busy && !fifo_empty && (r_rd_left != '0)
                       && (w_level < (3'(SKID_DEPTH) + 3'(w_pop)));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_busy    <= 1'b0;
            r_rd_left <= '0;
            r_tx_left <= '0;
            r_rd_pipe <= '0;
        end else begin
            r_rd_pipe <= rd_pipe_t'({r_rd_pipe, w_read_en});
            if (w_accept) begin
                r_busy    <= 1'b1;
                r_rd_left <= len;
                r_tx_left <= len;
            end else begin
                if (w_read_en) r_rd_left <= r_rd_left - LEN_W'(1);
                if (w_pop) begin
                    r_tx_left <= r_tx_left - LEN_W'(1);
                    if (r_tx_left == LEN_W'(1)) r_busy <= 1'b0;
                end
            end
        end
    end

    iob_skid_buf2 #(.W(DATA_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (fifo_r_data),
        .pop       (w_pop),
        .valid     (m_valid),
        .data      (m_data),
        .occ       (w_occ)
    );

    assign busy         = r_busy;
    assign fifo_read_en = w_read_en;
    assign m_last       = m_valid && (r_tx_left == LEN_W'(1));

endmodule
